// File: rtl/mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_drain
// Description : Snapshots the MAC accumulator array on start and streams it out
//               one row per valid/ready beat. Optional MAC_DRAIN_RELU_EN clamps
//               negative output elements to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_drain #(
    parameter int MAC_WIDTH     = 8,
    parameter int ACC_WIDTH     = 32,
    parameter int ROW_IDX_WIDTH = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [MAC_WIDTH*MAC_WIDTH*ACC_WIDTH-1:0] accumulators,
    output logic                                   clear_acc,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [MAC_WIDTH*ACC_WIDTH-1:0]         out_data,
    output logic [ROW_IDX_WIDTH-1:0]               out_row,
    output logic                                   out_last
);

    localparam int C_ROW_BITS = MAC_WIDTH * ACC_WIDTH;
    localparam logic [ROW_IDX_WIDTH-1:0] C_LAST_ROW = ROW_IDX_WIDTH'(MAC_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [ROW_IDX_WIDTH-1:0]  r_row;
    logic [ROW_IDX_WIDTH-1:0]  w_row_next;
    logic                      r_clear;
    logic                      w_clear_next;
    logic                      r_done;
    logic                      w_done_next;
    logic                      w_accept;
    logic                      w_last;
    logic [C_ROW_BITS-1:0]     r_snap [MAC_WIDTH];
    logic [C_ROW_BITS-1:0]     w_row_raw;

    assign w_last = (r_row == C_LAST_ROW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_clear <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_clear <= w_clear_next;
            r_done  <= w_done_next;
        end
    end

    // Row counter returns to 0 on the last beat so out_row idles at 0.
    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_clear_next = 1'b0;
        w_done_next  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = STREAM;
                    w_row_next   = '0;
                    w_clear_next = 1'b1;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_state_next = IDLE;
                        w_row_next   = '0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_row_next = r_row + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_row_next   = '0;
            end
        endcase
    end

    // Snapshot holds raw data only; it is never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < MAC_WIDTH; i++) begin
                r_snap[i] <= accumulators[i*C_ROW_BITS +: C_ROW_BITS];
            end
        end
    end

    always_comb begin
        w_row_raw = '0;
        for (int i = 0; i < MAC_WIDTH; i++) begin
            if (r_row == ROW_IDX_WIDTH'(i)) begin
                w_row_raw = r_snap[i];
            end
        end
    end

    assign out_valid = (r_state == STREAM);
    assign busy      = (r_state == STREAM);
    assign out_row   = r_row;
    assign out_last  = out_valid & w_last;
    assign clear_acc = r_clear;
    assign done      = r_done;

    generate
        for (genvar j = 0; j < MAC_WIDTH; j++) begin : g_elem
            logic [ACC_WIDTH-1:0] w_elem;
            assign w_elem = w_row_raw[j*ACC_WIDTH +: ACC_WIDTH];
`ifdef MAC_DRAIN_RELU_EN
            assign out_data[j*ACC_WIDTH +: ACC_WIDTH] =
                (out_valid && !w_elem[ACC_WIDTH-1]) ? w_elem : '0;
`else
            assign out_data[j*ACC_WIDTH +: ACC_WIDTH] = out_valid ? w_elem : '0;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mac_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_result_drain
// Description : Self-checking bench for mac_result_drain (2x2 array, 32-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_result_drain;

    localparam int MW  = 2;
    localparam int AW  = 32;
    localparam int RIW = 2;
    localparam int RB  = MW * AW;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [MW*MW*AW-1:0]   accumulators = '0;
    logic                  clear_acc;
    logic                  busy;
    logic                  done;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [RB-1:0]         out_data;
    logic [RIW-1:0]        out_row;
    logic                  out_last;

    int checks = 0;
    int errors = 0;

    mac_result_drain #(
        .MAC_WIDTH    (MW),
        .ACC_WIDTH    (AW),
        .ROW_IDX_WIDTH(RIW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .accumulators(accumulators),
        .clear_acc   (clear_acc),
        .busy        (busy),
        .done        (done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] xf(input logic [AW-1:0] v);
`ifdef MAC_DRAIN_RELU_EN
        return v[AW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Behavioural model: a drain is "active" from accept until the last row is taken.
    logic                m_active = 1'b0;
    int                  m_row    = 0;
    logic                m_clr    = 1'b0;
    logic                m_done   = 1'b0;
    logic [MW*MW*AW-1:0] m_snap   = '0;

    function automatic logic [RB-1:0] exp_row(input int r);
        logic [RB-1:0] res;
        res = '0;
        for (int j = 0; j < MW; j++) res[j*AW +: AW] = xf(m_snap[(r*MW+j)*AW +: AW]);
        return res;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_row = 0; m_clr = 1'b0; m_done = 1'b0;
        end else begin
            m_clr  = 1'b0;
            m_done = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_snap = accumulators; m_row = 0; m_active = 1'b1; m_clr = 1'b1;
                end
            end else if (out_ready) begin
                if (m_row == MW - 1) begin
                    m_active = 1'b0; m_done = 1'b1; m_row = 0;
                end else begin
                    m_row = m_row + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 64'(busy), 64'(m_active));
            chk("out_valid", 64'(out_valid), 64'(m_active));
            chk("clear_acc", 64'(clear_acc), 64'(m_clr));
            chk("done", 64'(done), 64'(m_done));
            if (m_active) begin
                chk("out_row", 64'(out_row), 64'(m_row));
                chk("out_last", 64'(out_last), 64'(m_row == MW - 1));
                chk("out_data", out_data, exp_row(m_row));
            end
        end
    end

    // Handshake log for the directed literal checks.
    logic [RB-1:0] log_data[$];
    int            log_row[$];
    logic          log_last[$];
    int            clr_cnt = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                log_data.push_back(out_data);
                log_row.push_back(int'(out_row));
                log_last.push_back(out_last);
            end
            if (clear_acc) clr_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic clear_log();
        log_data.delete(); log_row.delete(); log_last.delete();
        clr_cnt = 0; done_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (1) begin
            @(negedge clk);
            if (done) break;
            if (c >= 40) begin
                checks++; errors++;
                $display("FAIL wait_done: got timeout expected done pulse");
                break;
            end
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic check_two_beats(input string tag, input logic [RB-1:0] d0, input logic [RB-1:0] d1);
        chk({tag, "_beats"}, 64'(log_data.size()), 64'd2);
        if (log_data.size() >= 2) begin
            chk({tag, "_row0"}, 64'(log_row[0]), 64'd0);
            chk({tag, "_data0"}, log_data[0], d0);
            chk({tag, "_last0"}, 64'(log_last[0]), 64'd0);
            chk({tag, "_row1"}, 64'(log_row[1]), 64'd1);
            chk({tag, "_data1"}, log_data[1], d1);
            chk({tag, "_last1"}, 64'(log_last[1]), 64'd1);
        end
    endtask

    localparam logic [MW*MW*AW-1:0] C_BASIC = {32'd4, 32'd3, 32'd2, 32'd1};

    initial begin
        int c;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_clear", 64'(clear_acc), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_row", 64'(out_row), 64'd0);
        chk("reset_last", 64'(out_last), 64'd0);
        step();

        // Basic drain
        clear_log();
        accumulators = C_BASIC; out_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        wait_done(c);
        step();
        chk("basic_latency", 64'(c), 64'd3);
        chk("basic_clear_cnt", 64'(clr_cnt), 64'd1);
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);
        check_two_beats("basic", 64'h00000002_00000001, 64'h00000004_00000003);

        // Backpressure: beat0 held for 4 cycles
        clear_log();
        out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        out_ready = 1'b1;
        wait_done(c);
        step();
        check_two_beats("bp", 64'h00000002_00000001, 64'h00000004_00000003);

        // Snapshot isolation
        clear_log();
        start = 1'b1;
        step(); start = 1'b0; accumulators = '1;
        wait_done(c);
        step();
        check_two_beats("iso", 64'h00000002_00000001, 64'h00000004_00000003);

        // start while busy is ignored; start in done cycle is accepted
        clear_log();
        accumulators = C_BASIC; start = 1'b1;
        step(); start = 1'b0;
        step(); start = 1'b1;
        step();
        step(); start = 1'b0;
        chk("busy_start_beats", 64'(log_data.size()), 64'd2);
        chk("busy_start_done", 64'(done_cnt), 64'd1);
        chk("busy_start_clear", 64'(clr_cnt), 64'd1);
        @(negedge clk);
        chk("b2b_clear", 64'(clear_acc), 64'd1);
        chk("b2b_valid", 64'(out_valid), 64'd1);
        wait_done(c);
        step();
        chk("b2b_done_cnt", 64'(done_cnt), 64'd2);
        chk("b2b_beats", 64'(log_data.size()), 64'd4);

        // Asynchronous reset mid-stream
        clear_log();
        out_ready = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_clear", 64'(clear_acc), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        step(); step();
        rst = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("arst_idle_valid", 64'(out_valid), 64'd0);
        chk("arst_no_done", 64'(done_cnt), 64'd0);
        chk("arst_no_beats", 64'(log_data.size()), 64'd0);

        // ReLU element test
        clear_log();
        accumulators = {32'd0, 32'd0, 32'd7, 32'hFFFF_FFFB}; start = 1'b1;
        step(); start = 1'b0;
        wait_done(c);
        step();
        chk("relu_beats", 64'(log_data.size()), 64'd2);
        if (log_data.size() >= 1) begin
`ifdef MAC_DRAIN_RELU_EN
            chk("relu_data0", log_data[0], 64'h00000007_00000000);
`else
            chk("relu_data0", log_data[0], 64'h00000007_FFFFFFFB);
`endif
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            accumulators = {$urandom, $urandom, $urandom, $urandom};
            start        = ($urandom_range(0, 3) == 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            step();
        end
        start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
